// File: rtl/mant_mul_arbiter_if.sv
// Requester and multiplier channels of the shared mantissa multiplier arbiter.
// Latency: none, wires only.
// Backpressure: req_ready/resp_ready valid-ready handshakes; the multiplier side is start/done.
interface mant_mul_arbiter_if #(
    parameter int N = 12
) ();
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [2*N-1:0] resp_product;
    logic           resp_err;
    logic           mul_start;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic           mul_done;
    logic [2*N-1:0] mul_product;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_done, mul_product,
        output req_ready, resp_valid, resp_product, resp_err, mul_start, mul_a, mul_b
    );

    // Requesters plus the multiplier.
    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_done, mul_product,
        input  req_ready, resp_valid, resp_product, resp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mant_mul_arbiter.sv
// Round-robin arbiter sharing one iterative NxN mantissa multiplier between two requesters.
// Latency: accept t, mul_start t+1, response valid the cycle after mul_done; one op in flight.
// Backpressure: req_ready only in IDLE; RESP holds until resp_ready of the grantee. Option: MUL_TIMEOUT_EN.
module mant_mul_arbiter #(
    parameter int N = 12
`ifdef MUL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 2*N+4
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    mant_mul_arbiter_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           rr_ptr_q, rr_ptr_d;
    logic           grant_q, grant_d;
    logic [N-1:0]   mul_a_q, mul_a_d;
    logic [N-1:0]   mul_b_q, mul_b_d;
    logic [2*N-1:0] prod_q, prod_d;
`ifdef MUL_TIMEOUT_EN
    logic           err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;
`endif

    logic           win_vld;
    logic           win_id;
    logic           accept;

    // Arbitration: a lone requester wins; on contention rr_ptr picks.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
        case (bus.req_valid)
            2'b01:   begin win_vld = 1'b1; win_id = 1'b0;     end
            2'b10:   begin win_vld = 1'b1; win_id = 1'b1;     end
            2'b11:   begin win_vld = 1'b1; win_id = rr_ptr_q; end
            default: begin win_vld = 1'b0; win_id = 1'b0;     end
        endcase
        bus.req_ready = 2'b00;
        if (state_q == S_IDLE && win_vld) begin
            bus.req_ready = win_id ? 2'b10 : 2'b01;
        end
        accept = |(bus.req_valid & bus.req_ready);
    end

    // Next-state logic: operand capture, start issue, result capture, response handshake.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        prod_d   = prod_q;
`ifdef MUL_TIMEOUT_EN
        err_d    = err_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mul_a_d  = win_id ? bus.req_a[N +: N] : bus.req_a[0 +: N];
                    mul_b_d  = win_id ? bus.req_b[N +: N] : bus.req_b[0 +: N];
                    grant_d  = win_id;
                    // Loser of this round gets priority next time.
                    rr_ptr_d = ~win_id;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef MUL_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_done) begin
                    // A done on the expiry cycle still counts as a good result.
                    prod_d  = bus.mul_product;
`ifdef MUL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef MUL_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                if (bus.resp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            grant_q  <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            prod_q   <= '0;
`ifdef MUL_TIMEOUT_EN
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            prod_q   <= prod_d;
`ifdef MUL_TIMEOUT_EN
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.mul_start    = (state_q == S_ISSUE);
        bus.mul_a        = mul_a_q;
        bus.mul_b        = mul_b_q;
        bus.resp_valid   = 2'b00;
        if (state_q == S_RESP) begin
            bus.resp_valid = grant_q ? 2'b10 : 2'b01;
        end
        bus.resp_product = prod_q;
`ifdef MUL_TIMEOUT_EN
        bus.resp_err     = err_q;
`else
        bus.resp_err     = 1'b0;
`endif
        busy             = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed bench for mant_mul_arbiter with a behavioural multiplier model.
// Latency: multiplier model answers mul_lat cycles after seeing mul_start.
// Backpressure: responses are accepted or withheld by the directed steps.
module tb_mant_mul_arbiter;

    logic clk;
    logic rstn;
    logic busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mul_lat  = 3;
    bit   mul_hold = 1'b0;
    int   start_cnt = 0;
    int   s0;

    mant_mul_arbiter_if #(.N(12)) bus ();

    mant_mul_arbiter #(.N(12)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag);
        int k;
        k = 0;
        while (bus.resp_valid == 2'b00 && k < 100) begin
            tick();
            k++;
        end
        check(tag, (k < 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Behavioural multiplier: counts starts, answers after mul_lat cycles unless held.
    initial begin
        int pend;
        pend            = -1;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mul_done = 1'b0;
            if (!rstn) begin
                pend = -1;
            end else begin
                if (bus.mul_start) begin
                    start_cnt++;
                    pend = mul_lat;
                end else if (pend > 0) begin
                    pend--;
                end
                if (pend == 0 && !mul_hold) begin
                    bus.mul_done    = 1'b1;
                    bus.mul_product = 24'(bus.mul_a) * 24'(bus.mul_b);
                    pend = -1;
                end
            end
        end
    end

    initial begin
        rstn           = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 2'b00;
        tick();
        tick();
        // Reset state
        check("rst_busy",      busy,             0);
        check("rst_req_ready", bus.req_ready,    0);
        check("rst_resp_vld",  bus.resp_valid,   0);
        check("rst_product",   bus.resp_product, 0);
        check("rst_err",       bus.resp_err,     0);
        check("rst_start",     bus.mul_start,    0);
        check("rst_mul_a",     bus.mul_a,        0);
        check("rst_mul_b",     bus.mul_b,        0);
        rstn = 1'b1;

        // 1: requester 0 alone, 3*5
        s0 = start_cnt;
        tick();
        bus.req_valid = 2'b01;
        bus.req_a = {12'h000, 12'h003};
        bus.req_b = {12'h000, 12'h005};
        #1;
        check("t1_req_ready", bus.req_ready, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("t1_start", bus.mul_start, 1);
        check("t1_mul_a", bus.mul_a, 32'h003);
        check("t1_mul_b", bus.mul_b, 32'h005);
        check("t1_busy",  busy, 1);
        tick();
        check("t1_start_pulse", bus.mul_start, 0);
        wait_resp("t1_resp_arrives");
        check("t1_resp_vld", bus.resp_valid, 32'h1);
        check("t1_product",  bus.resp_product, 32'h000F);
        check("t1_err",      bus.resp_err, 0);
        check("t1_nstarts",  start_cnt - s0, 1);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        check("t1_idle", busy, 0);

        // 2: both valid after reset, max operands
        do_reset();
        tick();
        bus.req_valid = 2'b11;
        bus.req_a = {12'hFFF, 12'hFFF};
        bus.req_b = {12'hFFF, 12'hFFF};
        #1;
        check("t2_first_grant", bus.req_ready, 32'h1);
        tick();
        wait_resp("t2_resp0_arrives");
        check("t2_resp0_vld", bus.resp_valid, 32'h1);
        check("t2_product0",  bus.resp_product, 32'hFFE001);
        check("t2_rdy_in_resp", bus.req_ready, 0);
        bus.resp_ready = 2'b11;
        tick();
        bus.resp_ready = 2'b00;
        #1;
        check("t2_second_grant", bus.req_ready, 32'h2);
        tick();
        bus.req_valid = 2'b00;
        wait_resp("t2_resp1_arrives");
        check("t2_resp1_vld", bus.resp_valid, 32'h2);
        check("t2_product1",  bus.resp_product, 32'hFFE001);
        bus.resp_ready = 2'b11;
        tick();
        bus.resp_ready = 2'b00;

        // 3: continuous contention, alternating grants; requester 1 has a zero operand
        bus.req_a = {12'h000, 12'h012};
        bus.req_b = {12'h7AB, 12'h034};
        bus.req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t3_grant", bus.req_ready, (i % 2 == 1) ? 32'h2 : 32'h1);
            tick();
            wait_resp("t3_resp_arrives");
            check("t3_resp_vld", bus.resp_valid, (i % 2 == 1) ? 32'h2 : 32'h1);
            check("t3_product",  bus.resp_product, (i % 2 == 1) ? 32'h0 : 32'h3A8);
            bus.resp_ready = 2'b11;
            tick();
            bus.resp_ready = 2'b00;
            #1;
        end
        bus.req_valid = 2'b00;

        // 4: response stalled 10 cycles, other requester waiting, wrong-side ready
        tick();
        bus.req_valid = 2'b01;
        bus.req_a = {12'h000, 12'h00A};
        bus.req_b = {12'h000, 12'h00B};
        #1;
        tick();
        bus.req_valid = 2'b10;
        wait_resp("t4_resp_arrives");
        s0 = start_cnt;
        bus.resp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_vld",  bus.resp_valid, 32'h1);
            check("t4_hold_prod", bus.resp_product, 32'h6E);
            check("t4_hold_rdy",  bus.req_ready, 0);
        end
        check("t4_no_start", start_cnt - s0, 0);
        bus.resp_ready = 2'b01;
        bus.req_valid  = 2'b00;
        tick();
        bus.resp_ready = 2'b00;
        check("t4_idle", busy, 0);

        // 5: reset during WAIT, then a clean operation
        mul_lat = 10;
        tick();
        bus.req_valid = 2'b01;
        bus.req_a = {12'h000, 12'h005};
        bus.req_b = {12'h000, 12'h007};
        #1;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        check("t5_wait_busy", busy, 1);
        check("t5_wait_nvld", bus.resp_valid, 0);
        rstn = 1'b0;
        #1;
        check("t5_rst_busy",  busy, 0);
        check("t5_rst_mul_a", bus.mul_a, 0);
        check("t5_rst_mul_b", bus.mul_b, 0);
        check("t5_rst_start", bus.mul_start, 0);
        check("t5_rst_prod",  bus.resp_product, 0);
        check("t5_rst_vld",   bus.resp_valid, 0);
        tick();
        tick();
        rstn = 1'b1;
        mul_lat = 3;
        tick();
        bus.req_valid = 2'b01;
        bus.req_a = {12'h000, 12'h021};
        bus.req_b = {12'h000, 12'h003};
        #1;
        check("t5_req_ready", bus.req_ready, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        wait_resp("t5_resp_arrives");
        check("t5_resp_vld", bus.resp_valid, 32'h1);
        check("t5_product",  bus.resp_product, 32'h63);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;

        // 6: multiplier never answers
        mul_hold = 1'b1;
        tick();
        bus.req_valid = 2'b01;
        bus.req_a = {12'h000, 12'h002};
        bus.req_b = {12'h000, 12'h003};
        #1;
        tick();
        bus.req_valid = 2'b00;
        tick();
`ifdef MUL_TIMEOUT_EN
        repeat (27) tick();
        check("t6_before_expiry", bus.resp_valid, 0);
        check("t6_busy", busy, 1);
        tick();
        check("t6_timeout_vld",  bus.resp_valid, 32'h1);
        check("t6_timeout_err",  bus.resp_err, 1);
        check("t6_timeout_prod", bus.resp_product, 0);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        check("t6_idle", busy, 0);
`else
        repeat (40) tick();
        check("t6_stuck_busy", busy, 1);
        check("t6_stuck_nvld", bus.resp_valid, 0);
        check("t6_err_zero",   bus.resp_err, 0);
`endif
        do_reset();
        mul_hold = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
